// File: rtl/obi_axil_master_if.sv
// obi_axil_master_if -- bundles the OBI data port and the AXI4-Lite master port
// of obi_axil_master into a single interface.
//   modport master : view taken by the bridge (drives gnt/rvalid/rdata/err and AXI requests)
//   modport slave  : view taken by the environment (core LSU plus AXI4-Lite slave)
// OBI side : data_req_i, data_gnt_o, data_addr_i, data_we_i, data_be_i, data_wdata_i,
//            data_rvalid_o, data_rdata_o, data_err_o
// AXI side : AW (m_awaddr/m_awvalid/m_awready), W (m_wdata/m_wstrb/m_wvalid/m_wready),
//            B (m_bvalid/m_bready), AR (m_araddr/m_arvalid/m_arready),
//            R (m_rdata/m_rvalid/m_rready)
interface obi_axil_master_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bvalid, m_arready, m_rdata, m_rvalid
    );

    modport slave (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bvalid, m_arready, m_rdata, m_rvalid
    );
endinterface

// File: rtl/obi_axil_master.sv
// obi_axil_master -- bridges a core OBI data port onto an AXI4-Lite master port with a
// single transaction outstanding at a time.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : obi_axil_master_if.master (OBI request/response and the five AXI4-Lite channels)
// Parameter:
//   TIMEOUT_CYCLES : watchdog limit in cycles for one outstanding AXI transaction
// Compile-time option:
//   OBI_AXIL_TIMEOUT_EN : adds the watchdog; on expiry the transaction is abandoned and
//                         the core sees a response with data_err_o = 1. Without it the
//                         bridge waits indefinitely and data_err_o is tied to 0.
module obi_axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic               clk,
    input logic               rst,
    obi_axil_master_if.master bus
);
    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic w_gnt;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_done;
    logic w_timeout;

    // Grant is masked by rst so nothing is accepted while the bridge is held in reset.
    assign w_gnt   = bus.data_req_i && (r_state == StIdle) && !rst;
    assign w_aw_hs = bus.m_awvalid && bus.m_awready;
    assign w_w_hs  = bus.m_wvalid && bus.m_wready;
    assign w_ar_hs = bus.m_arvalid && bus.m_arready;
    assign w_b_hs  = bus.m_bvalid && bus.m_bready;
    assign w_r_hs  = bus.m_rvalid && bus.m_rready;
    assign w_done  = w_b_hs || w_r_hs;

`ifdef OBI_AXIL_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_err;

    // A completion on the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state != StIdle) && (r_cnt == TIMEOUT_CYCLES - 1) && !w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == StIdle) ? '0 : r_cnt + 32'd1;
            r_err <= w_timeout;
        end
    end

    assign bus.data_err_o = r_err;
`else
    assign w_timeout      = 1'b0;
    assign bus.data_err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        assert (TIMEOUT_CYCLES >= 32'd2);
        unique case (r_state)
            StIdle:   if (w_gnt) w_state_next = bus.data_we_i ? StWrReq : StRdReq;
            // Leave once both AW and W have been accepted, either earlier or on this edge.
            StWrReq:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = StWrResp;
            StWrResp: if (w_b_hs) w_state_next = StIdle;
            StRdReq:  if (w_ar_hs) w_state_next = StRdResp;
            StRdResp: if (w_r_hs) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
        if (w_timeout) w_state_next = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_gnt) begin
                r_addr    <= bus.data_addr_i & 32'hFFFF_FFFC;
                r_wdata   <= bus.data_wdata_i;
                r_be      <= bus.data_be_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            r_rvalid <= w_done || w_timeout;
            // Read data is captured on R; writes and timeouts return zero; otherwise hold.
            if (w_r_hs)                    r_rdata <= bus.m_rdata;
            else if (w_b_hs || w_timeout)  r_rdata <= '0;
        end
    end

    // Valid/ready are decoded from state so an asynchronous reset drops them at once.
    assign bus.m_awvalid = (r_state == StWrReq) && !r_aw_done;
    assign bus.m_wvalid  = (r_state == StWrReq) && !r_w_done;
    assign bus.m_bready  = (r_state == StWrResp);
    assign bus.m_arvalid = (r_state == StRdReq);
    assign bus.m_rready  = (r_state == StRdResp);

    assign bus.m_awaddr  = r_addr;
    assign bus.m_araddr  = r_addr;
    assign bus.m_wdata   = r_wdata;
    assign bus.m_wstrb   = r_be;

    assign bus.data_gnt_o    = w_gnt;
    assign bus.data_rvalid_o = r_rvalid;
    assign bus.data_rdata_o  = r_rdata;
endmodule

// File: tb/tb_obi_axil_master.sv
// tb_obi_axil_master -- directed self-checking bench for obi_axil_master.
// Drives the OBI side and a hand-scripted AXI4-Lite slave through the interface.
// Inputs change 1 time unit after a rising edge; outputs are checked 2 units after it.
module tb_obi_axil_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    obi_axil_master_if bus();

    obi_axil_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = 32'h0;
    endtask

    task automatic test_reset;
        slave_idle();
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = 32'h0000_0104;
        bus.data_be_i    = 4'hF;
        bus.data_wdata_i = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 0", bus.data_gnt_o);
        end
        n_checks++;
        if ({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valid_ready: got %b want 00000",
                {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready});
        end
        n_checks++;
        if ({bus.data_rvalid_o, bus.data_err_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rvalid_err: got %b want 00",
                {bus.data_rvalid_o, bus.data_err_o});
        end
        n_checks++;
        if (bus.data_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.data_rdata_o);
        end
        n_checks++;
        if ({bus.m_awaddr, bus.m_araddr, bus.m_wdata} !== 96'h0 || bus.m_wstrb !== 4'h0) begin
            n_fail++; $display("FAIL reset_addr_data: aw %h ar %h wd %h strb %h want all 0",
                bus.m_awaddr, bus.m_araddr, bus.m_wdata, bus.m_wstrb);
        end
        tick();
        rst = 1'b0;
        bus.data_req_i = 1'b0;
    endtask

    // Zero-wait read directly after reset release.
    task automatic test_read;
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rdata   = 32'hDEAD_BEEF;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0000_0104;
        bus.data_be_i   = 4'h0;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL read_first_gnt: got %b want 1", bus.data_gnt_o);
        end
        tick();
        bus.data_req_i = 1'b0;
        #1;
        n_checks++;
        if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h0000_0104) begin
            n_fail++; $display("FAIL read_ar: arvalid %b araddr %h want 1 00000104",
                bus.m_arvalid, bus.m_araddr);
        end
        tick();
        #1;
        n_checks++;
        if (bus.m_arvalid !== 1'b0 || bus.m_rready !== 1'b1 || bus.data_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL read_rresp: arvalid %b rready %b rvalid_o %b want 0 1 0",
                bus.m_arvalid, bus.m_rready, bus.data_rvalid_o);
        end
        tick();
        #1;
        n_checks++;
        if (bus.data_rvalid_o !== 1'b1 || bus.data_rdata_o !== 32'hDEAD_BEEF
            || bus.data_err_o !== 1'b0) begin
            n_fail++; $display("FAIL read_resp: rvalid %b rdata %h err %b want 1 deadbeef 0",
                bus.data_rvalid_o, bus.data_rdata_o, bus.data_err_o);
        end
        tick();
        #1;
        n_checks++;
        if (bus.data_rvalid_o !== 1'b0 || bus.data_rdata_o !== 32'hDEAD_BEEF
            || bus.m_rready !== 1'b0) begin
            n_fail++; $display("FAIL read_hold: rvalid %b rdata %h rready %b want 0 deadbeef 0",
                bus.data_rvalid_o, bus.data_rdata_o, bus.m_rready);
        end
        slave_idle();
    endtask

    // Unaligned write address is forced to word alignment; response data is zero.
    task automatic test_write;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.m_bvalid  = 1'b1;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_addr_i  = 32'h0000_0013;
        bus.data_be_i    = 4'b0100;
        bus.data_wdata_i = 32'h00AB_0000;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL write_gnt: got %b want 1", bus.data_gnt_o);
        end
        tick();
        bus.data_req_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.m_awvalid, bus.m_wvalid} !== 2'b11 || bus.m_awaddr !== 32'h0000_0010
            || bus.m_wstrb !== 4'b0100 || bus.m_wdata !== 32'h00AB_0000) begin
            n_fail++; $display("FAIL write_req: v %b awaddr %h strb %b wdata %h want 11 10 0100 00ab0000",
                {bus.m_awvalid, bus.m_wvalid}, bus.m_awaddr, bus.m_wstrb, bus.m_wdata);
        end
        tick();
        #1;
        n_checks++;
        if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready} !== 3'b001) begin
            n_fail++; $display("FAIL write_bresp: aw/w/bready %b want 001",
                {bus.m_awvalid, bus.m_wvalid, bus.m_bready});
        end
        tick();
        #1;
        n_checks++;
        if (bus.data_rvalid_o !== 1'b1 || bus.data_rdata_o !== 32'h0 || bus.data_err_o !== 1'b0) begin
            n_fail++; $display("FAIL write_resp: rvalid %b rdata %h err %b want 1 0 0",
                bus.data_rvalid_o, bus.data_rdata_o, bus.data_err_o);
        end
        tick();
        #1;
        n_checks++;
        if (bus.data_rvalid_o !== 1'b0 || bus.m_bready !== 1'b0) begin
            n_fail++; $display("FAIL write_done: rvalid %b bready %b want 0 0",
                bus.data_rvalid_o, bus.m_bready);
        end
        slave_idle();
    endtask

    // AW stalled 4 cycles while W is accepted immediately.
    task automatic test_aw_stall;
        int aw_cnt = 0;
        int w_cnt = 0;
        int b_cnt = 0;
        int rv_cnt = 0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b1;
        bus.m_bvalid  = 1'b1;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_addr_i  = 32'h0000_0020;
        bus.data_be_i    = 4'hF;
        bus.data_wdata_i = 32'h1122_3344;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_gnt: got %b want 1", bus.data_gnt_o);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.data_req_i = 1'b0;
            bus.m_awready  = (k >= 5);
            #1;
            aw_cnt += int'(bus.m_awvalid);
            w_cnt  += int'(bus.m_wvalid);
            b_cnt  += int'(bus.m_bvalid && bus.m_bready);
            rv_cnt += int'(bus.data_rvalid_o);
            if (k == 7) begin
                n_checks++;
                if (bus.data_rvalid_o !== 1'b1) begin
                    n_fail++; $display("FAIL stall_resp_cycle: rvalid %b want 1", bus.data_rvalid_o);
                end
            end
        end
        n_checks++;
        if (aw_cnt != 5 || w_cnt != 1) begin
            n_fail++; $display("FAIL stall_valid_len: awvalid %0d wvalid %0d cycles want 5 1",
                aw_cnt, w_cnt);
        end
        n_checks++;
        if (b_cnt != 1 || rv_cnt != 1) begin
            n_fail++; $display("FAIL stall_resp_count: b hs %0d rvalid %0d want 1 1", b_cnt, rv_cnt);
        end
        slave_idle();
    endtask

    // Read then write with req held high: second grant coincides with the first response.
    task automatic test_back_to_back;
        int overlap = 0;
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rdata   = 32'h1234_5678;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.m_bvalid  = 1'b1;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = 32'h0000_0200;
        bus.data_be_i    = 4'hF;
        bus.data_wdata_i = 32'h0;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gnt0: got %b want 1", bus.data_gnt_o);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                bus.data_we_i    = 1'b1;
                bus.data_addr_i  = 32'h0000_0300;
                bus.data_be_i    = 4'b0011;
                bus.data_wdata_i = 32'hCAFE_F00D;
            end
            if (k == 4) bus.data_req_i = 1'b0;
            #1;
            if (bus.m_arvalid && (bus.m_awvalid || bus.m_wvalid)) overlap++;
            n_checks++;
            if (bus.data_gnt_o !== (k == 3) || bus.data_rvalid_o !== (k == 3 || k == 6)) begin
                n_fail++; $display("FAIL b2b_cycle%0d: gnt %b rvalid %b want %b %b", k,
                    bus.data_gnt_o, bus.data_rvalid_o, (k == 3), (k == 3 || k == 6));
            end
            if (k == 3) begin
                n_checks++;
                if (bus.data_rdata_o !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL b2b_rdata: got %h want 12345678", bus.data_rdata_o);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (bus.m_awaddr !== 32'h0000_0300 || bus.m_wstrb !== 4'b0011) begin
                    n_fail++; $display("FAIL b2b_wr_fields: awaddr %h strb %b want 300 0011",
                        bus.m_awaddr, bus.m_wstrb);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (bus.data_rdata_o !== 32'h0) begin
                    n_fail++; $display("FAIL b2b_wdata_resp: got %h want 0", bus.data_rdata_o);
                end
            end
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++; $display("FAIL b2b_overlap: got %0d cycles want 0", overlap);
        end
        slave_idle();
    endtask

    // Reset asserted while AR is stalled, then a fresh read.
    task automatic test_reset_mid;
        int rv_cnt = 0;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0000_0040;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b want 1", bus.data_gnt_o);
        end
        tick();
        bus.data_req_i = 1'b0;
        #1;
        n_checks++;
        if (bus.m_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_arvalid: got %b want 1", bus.m_arvalid);
        end
        #2;
        bus.data_req_i = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.m_arvalid !== 1'b0 || bus.data_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: arvalid %b gnt %b want 0 0",
                bus.m_arvalid, bus.data_gnt_o);
        end
        tick();
        rst = 1'b0;
        bus.data_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            rv_cnt += int'(bus.data_rvalid_o);
            tick();
        end
        n_checks++;
        if (rv_cnt != 0) begin
            n_fail++; $display("FAIL rstmid_no_resp: rvalid cycles %0d want 0", rv_cnt);
        end
        bus.m_arready   = 1'b1;
        bus.m_rvalid    = 1'b1;
        bus.m_rdata     = 32'h55AA_55AA;
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h0000_0048;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_regnt: got %b want 1", bus.data_gnt_o);
        end
        tick();
        bus.data_req_i = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if (bus.data_rvalid_o !== 1'b1 || bus.data_rdata_o !== 32'h55AA_55AA) begin
            n_fail++; $display("FAIL rstmid_reread: rvalid %b rdata %h want 1 55aa55aa",
                bus.data_rvalid_o, bus.data_rdata_o);
        end
        slave_idle();
        tick();
    endtask

`ifdef OBI_AXIL_TIMEOUT_EN
    // Slave accepts AR but never returns R; watchdog fires after 16 cycles.
    task automatic test_timeout;
        int rv_cnt = 0;
        int late_rready = 0;
        bus.m_arready   = 1'b1;
        bus.m_rvalid    = 1'b0;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0000_0080;
        #1;
        n_checks++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL tmo_gnt: got %b want 1", bus.data_gnt_o);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            bus.data_req_i = 1'b0;
            #1;
            rv_cnt += int'(bus.data_rvalid_o);
            if (k >= 17) late_rready += int'(bus.m_rready);
            if (k == 17) begin
                n_checks++;
                if (bus.data_rvalid_o !== 1'b1 || bus.data_err_o !== 1'b1
                    || bus.data_rdata_o !== 32'h0) begin
                    n_fail++; $display("FAIL tmo_resp: rvalid %b err %b rdata %h want 1 1 0",
                        bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o);
                end
            end
        end
        n_checks++;
        if (rv_cnt != 1 || late_rready != 0) begin
            n_fail++; $display("FAIL tmo_after: rvalid cycles %0d late rready %0d want 1 0",
                rv_cnt, late_rready);
        end
        slave_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_aw_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef OBI_AXIL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t want finished", $time);
        $fatal(1, "time limit");
    end
endmodule
